// File: rtl/convolutional_layer.sv
// -----------------------------------------------------------------------------
// convolutional_layer
//
// Streaming 2-D box-filter stage. One raster-order pixel is accepted per
// enabled clock. A per-channel shift register holds the last
// (FILTER_SIZE-1)*IMAGE_SIZE + (FILTER_SIZE-1) accepted pixels. The
// FILTER_SIZE x FILTER_SIZE unit-weight window sum is produced
// combinationally. The bottom-right corner of that window is the pixel
// currently on input_data.
//
// Ports:
//   clk          in   single clock, rising edge
//   rst_n        in   synchronous active-low reset (clears history and position)
//   clk_en       in   accept the current pixel / advance
//   input_data   in   D_WIDTH*D_CHANNELS, current pixel, channel 0 in LSBs
//   output_data  out  Q_WIDTH*Q_CHANNELS, window sum replicated per output
//                     channel, wraps modulo 2^Q_WIDTH
//   valid        out  window at the current pixel lies fully inside the image
//
// Optional feature macro: CONV_BORDER_MASK_EN
//   When it is defined, output_data is forced to 0 whenever valid is 0.
//   When it is undefined (the default), the raw tap sum is always driven,
//   including windows that wrap across rows or across the image edge.
// -----------------------------------------------------------------------------
module convolutional_layer #(
    parameter int D_WIDTH     = 8,
    parameter int Q_WIDTH     = 16,
    parameter int D_CHANNELS  = 1,
    parameter int Q_CHANNELS  = 1,
    parameter int FILTER_SIZE = 2,
    parameter int IMAGE_SIZE  = 64
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            clk_en,
    input  logic [D_WIDTH*D_CHANNELS-1:0]   input_data,
    output logic [Q_WIDTH*Q_CHANNELS-1:0]   output_data,
    output logic                            valid
);

    localparam int DW = D_WIDTH * D_CHANNELS;
    localparam int L  = (FILTER_SIZE - 1) * IMAGE_SIZE + (FILTER_SIZE - 1);
    localparam int CW = (IMAGE_SIZE > 1) ? $clog2(IMAGE_SIZE) : 1;
    localparam logic [CW-1:0] LAST_POS = CW'(IMAGE_SIZE - 1);
    localparam logic [CW-1:0] EDGE_POS = CW'(FILTER_SIZE - 1);

    logic [DW-1:0]     r_buf  [L];
    logic [CW-1:0]     r_col;
    logic [CW-1:0]     r_row;

    // Tap k is x[n-k]. Tap 0 is the live input and tap k is r_buf[k-1].
    logic [DW-1:0]     w_taps [L+1];
    logic [Q_WIDTH-1:0] w_sum;
    logic              w_valid;

    assign w_taps[0] = input_data;

    genvar g;
    generate
        for (g = 1; g <= L; g++) begin : g_tap
            assign w_taps[g] = r_buf[g-1];
        end
    endgenerate

    // History shift register and raster position
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < L; i++) begin
                r_buf[i] <= '0;
            end
            r_col <= '0;
            r_row <= '0;
        end else if (clk_en) begin
            r_buf[0] <= input_data;
            for (int i = 1; i < L; i++) begin
                r_buf[i] <= r_buf[i-1];
            end
            if (r_col == LAST_POS) begin
                r_col <= '0;
                r_row <= (r_row == LAST_POS) ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    // Box sum over all input channels. Accumulating at Q_WIDTH gives the
    // modulo-2^Q_WIDTH wrap directly.
    always_comb begin
        w_sum = '0;
        for (int d = 0; d < D_CHANNELS; d++) begin
            for (int r = 0; r < FILTER_SIZE; r++) begin
                for (int c = 0; c < FILTER_SIZE; c++) begin
                    w_sum = w_sum + Q_WIDTH'(w_taps[r*IMAGE_SIZE + c][d*D_WIDTH +: D_WIDTH]);
                end
            end
        end
    end

    assign w_valid = clk_en && (r_row >= EDGE_POS) && (r_col >= EDGE_POS);
    assign valid   = w_valid;

`ifdef CONV_BORDER_MASK_EN
    assign output_data = w_valid ? {Q_CHANNELS{w_sum}} : '0;
`else
    assign output_data = {Q_CHANNELS{w_sum}};
`endif

endmodule

// File: tb/tb_convolutional_layer.sv
module tb_convolutional_layer;

    localparam int IMG = 64;
    localparam int F   = 2;
    localparam int L   = (F-1)*IMG + (F-1);

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clk_en = 1'b0;
    logic [7:0]  input_data = '0;
    logic [15:0] output_data;
    logic        valid;

    int checks = 0;
    int errors = 0;

    // Reference model state: accepted pixels since reset, newest first.
    logic [7:0] hist[$];
    int         npix = 0;

    convolutional_layer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clk_en      (clk_en),
        .input_data  (input_data),
        .output_data (output_data),
        .valid       (valid)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        hist.delete();
        npix = 0;
    endfunction

    function automatic void model_accept(input logic [7:0] x);
        hist.push_front(x);
        if (hist.size() > L) void'(hist.pop_back());
        npix++;
    endfunction

    function automatic logic model_valid(input logic en);
        int col, row;
        col = npix % IMG;
        row = (npix / IMG) % IMG;
        return en && (row >= F-1) && (col >= F-1);
    endfunction

    // Sum of x[n - r*IMG - c]. Pixels before the reset count as 0.
    function automatic logic [15:0] model_out(input logic [7:0] x, input logic en);
        logic [31:0] s;
        int k;
        s = 0;
        for (int r = 0; r < F; r++)
            for (int c = 0; c < F; c++) begin
                k = r*IMG + c;
                if (k == 0) s += x;
                else if (k <= hist.size()) s += hist[k-1];
            end
`ifdef CONV_BORDER_MASK_EN
        if (!model_valid(en)) s = 0;
`endif
        return s[15:0];
    endfunction

    // Applies inputs for one cycle. It returns after the negedge, where
    // outputs are sampled. The caller then calls finish_cycle.
    task automatic apply(input logic [7:0] x, input logic en);
        input_data = x;
        clk_en     = en;
        @(negedge clk);
    endtask

    task automatic finish_cycle();
        @(posedge clk);
        if (clk_en && rst_n) model_accept(input_data);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clk_en = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        logic [7:0] x;
        do_reset();
        x = 8'h37;
        apply(x, 1'b1);
        checks++;
        if (output_data !== 16'h0037 || valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_state out=%h valid=%b expected out=0037 valid=0", output_data, valid);
        end
        clk_en = 1'b0;
        @(posedge clk); #1;
        do_reset();
    endtask

    task automatic test_constant();
        logic [15:0] e;
        do_reset();
        for (int i = 0; i < 70; i++) begin
            apply(8'h05, 1'b1);
            e = 16'd5 * (1 + (i >= 1) + (i >= 64) + (i >= 65));
`ifdef CONV_BORDER_MASK_EN
            if (i < 65) e = 0;
`endif
            if (i == 0 || i == 1 || i == 64 || i == 65 || i == 69) begin
                checks++;
                if (output_data !== e || valid !== (i >= 65)) begin
                    errors++;
                    $display("FAIL const5 idx=%0d out=%h valid=%b expected out=%h valid=%b",
                             i, output_data, valid, e, (i >= 65));
                end
            end
            finish_cycle();
        end
    endtask

    task automatic test_random();
        logic [7:0] x;
        do_reset();
        for (int i = 0; i < 2048; i++) begin
            x = 8'($urandom);
            apply(x, 1'b1);
            checks++;
            if (output_data !== model_out(x, 1'b1) || valid !== model_valid(1'b1)) begin
                errors++;
                $display("FAIL random idx=%0d out=%h valid=%b expected out=%h valid=%b",
                         i, output_data, valid, model_out(x, 1'b1), model_valid(1'b1));
            end
            finish_cycle();
        end
    endtask

    task automatic test_max_value();
        do_reset();
        for (int i = 0; i < 200; i++) begin
            apply(8'hFF, 1'b1);
            if (i >= 65) begin
                checks++;
                if (output_data !== 16'h03FC) begin
                    errors++;
                    $display("FAIL max_ff idx=%0d out=%h expected 03fc", i, output_data);
                end
            end
            finish_cycle();
        end
    endtask

    task automatic test_stall();
        logic [7:0] x;
        logic       en;
        do_reset();
        for (int i = 0; i < 300; i++) begin
            en = !(i >= 150 && i < 160);
            x  = 8'($urandom);
            apply(x, en);
            checks++;
            if (output_data !== model_out(x, en) || valid !== model_valid(en)
                || (!en && valid !== 1'b0)) begin
                errors++;
                $display("FAIL stall idx=%0d en=%b out=%h valid=%b expected out=%h valid=%b",
                         i, en, output_data, valid, model_out(x, en), model_valid(en));
            end
            finish_cycle();
        end
    endtask

    task automatic test_valid_pattern();
        logic [7:0] x;
        int ones;
        do_reset();
        for (int img = 0; img < 2; img++) begin
            ones = 0;
            for (int i = 0; i < IMG*IMG; i++) begin
                x = 8'($urandom);
                apply(x, 1'b1);
                if (valid === 1'b1) ones++;
                if (valid !== ((i / IMG) >= 1 && (i % IMG) >= 1)) begin
                    checks++;
                    errors++;
                    $display("FAIL valid_pattern img=%0d idx=%0d valid=%b", img, i, valid);
                end
                finish_cycle();
            end
            checks++;
            if (ones !== 3969) begin
                errors++;
                $display("FAIL valid_count img=%0d count=%0d expected 3969", img, ones);
            end
        end
    endtask

    task automatic test_midreset();
        logic [7:0] x;
        int first_valid;
        do_reset();
        for (int i = 0; i < 100; i++) begin
            apply(8'($urandom), 1'b1);
            finish_cycle();
        end
        do_reset();
        first_valid = -1;
        for (int i = 0; i < 130; i++) begin
            x = 8'($urandom);
            apply(x, 1'b1);
            if (valid === 1'b1 && first_valid < 0) first_valid = i;
            checks++;
            if (output_data !== model_out(x, 1'b1) || valid !== model_valid(1'b1)) begin
                errors++;
                $display("FAIL midreset idx=%0d out=%h valid=%b expected out=%h valid=%b",
                         i, output_data, valid, model_out(x, 1'b1), model_valid(1'b1));
            end
            finish_cycle();
        end
        checks++;
        if (first_valid !== 65) begin
            errors++;
            $display("FAIL midreset_first_valid got=%0d expected 65", first_valid);
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_constant();
        test_random();
        test_max_value();
        test_stall();
        test_valid_pattern();
        test_midreset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
